uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
UART transmitter feeding the SOC TXD pin; the transmit counterpart of the SOC receive path.
- CPU-side write port pushes bytes into a small FIFO.
- Serializer drains the FIFO as 8N1 frames, LSB first, at CLKS_PER_BIT clocks per bit.
- Default timing: 25 MHz clk, 115200 baud, 217 clocks per bit.

Parameters:
CLKS_PER_BIT, 217, clocks per serial bit (25 MHz / 115200); legal values >= 2.
FIFO_AW, 4, FIFO address width; depth = 2^FIFO_AW = 16 entries.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
wr_en  input  1  push wr_data into FIFO this cycle
wr_data  input  8  byte to transmit
full  output  1  FIFO holds 2^FIFO_AW entries
empty  output  1  FIFO holds 0 entries
count  output  FIFO_AW+1  current FIFO occupancy
busy  output  1  serializer is not in IDLE
txd  output  1  serial line, idle high

Behaviour:
- Reset (async, active-high), values held while reset is asserted:
  - txd=1, busy=0, count=0, empty=1, full=0.
  - FSM in IDLE; baud counter, bit index and FIFO pointers cleared.
- Reset mid-frame: abort immediately, txd=1 in the same cycle (async), FIFO contents discarded.
- FIFO write:
  - wr_en && !full: store wr_data at wr_ptr; wr_ptr wraps modulo depth; count+1 next cycle.
  - wr_en && full: write ignored; no pointer or count change; no error flag.
- FIFO read: a pop occurs only in IDLE when !empty. rd_ptr wraps modulo depth.
- Simultaneous push and pop in one cycle: count unchanged. Push while full with a pop in the same cycle is still rejected, because full is evaluated before the pop.
- full, empty and count are registered and consistent in every cycle.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the option below is enabled).
  - IDLE: txd=1, busy=0. If !empty: pop into shift register, go to START, counter=0.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles. Then shift right; after bit 7 go to STOP, otherwise bit index+1.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency:
  - Write to empty FIFO at edge N: count=1 after edge N; pop and START at edge N+1; txd falls after edge N+1.
  - Frame length: exactly 10*CLKS_PER_BIT cycles (11* with parity).
- Back-to-back: when STOP ends and the FIFO is non-empty, IDLE lasts exactly 1 cycle (txd=1) before the next START. No other inter-frame gap.
- txd is driven from a register (glitch-free).
- busy=1 in every state except IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps at bit end.

Optional Feature:
UART_TX_PARITY_EN
- Defined: after DATA, a PARITY state drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then STOP. Frame is 11 bits.
- Undefined: no PARITY state; DATA goes directly to STOP. Frame is 10 bits (8N1).

Test Plan:
- Reset: hold reset 3 cycles with wr_en pulsed -> txd=1, busy=0, count=0, empty=1 throughout; no frame starts after release.
- Single byte: write 0x34 -> txd sequence 0,0,0,1,0,1,1,0,0,1, each level held exactly 217 clocks; busy high for 2170 cycles. With UART_TX_PARITY_EN, parity bit 1 is inserted before stop.
- Back-to-back: write 0x34,0x35,0x2F on consecutive cycles -> three frames separated by exactly 1 idle-high cycle; a bench UART receiver decodes 0x34,0x35,0x2F.
- FIFO full/overflow:
  - While the first frame transmits, write 17 bytes 0x00..0x10 -> full=1 with count=16.
  - The 17th write (0x10) is dropped.
  - Bytes received are the first-frame byte followed by 0x00..0x0F.
- Simultaneous push/pop: with count=5, assert wr_en on the cycle IDLE pops -> count stays 5; data order preserved.
- Reset mid-frame: assert reset during bit 3 of 0x39 -> txd=1 immediately, count=0; after release txd stays 1 and no further frames are sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a CPU-side write FIFO, LSB first, CLKS_PER_BIT clocks per bit.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               busy,
    output logic               txd
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNTW  = FIFO_AW + 1;
    localparam int unsigned CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [CNTW-1:0]     count_next;
    logic [CW-1:0]       baud_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic                push;
    logic                pop;
`ifdef UART_TX_PARITY_EN
    logic                parity;
`endif

    // full is sampled before any pop, so a push while full is always rejected
    assign push       = wr_en && !full;
    assign pop        = (state == IDLE) && !empty;
    assign count_next = count + CNTW'(push) - CNTW'(pop);

    // FIFO storage (not reset; contents are invalidated by the pointers)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and registered occupancy flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNTW'(DEPTH));
        end
    end

    // Serializer; txd and busy are loaded with the level of the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    txd  <= 1'b1;
                    busy <= 1'b0;
                    if (!empty) begin
                        shift    <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity   <= ^mem[rd_ptr];
`endif
                        baud_cnt <= '0;
                        state    <= START;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        txd      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= parity;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        txd      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_cnt == BIT_END) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        txd      <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: reset/latency vector table, waveform check,
// bench-side UART receiver, back-to-back, overflow, push/pop and mid-frame reset sequences.
module tb_uart_tx_fifo;

    localparam int C  = 217;
    localparam int AW = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * C;
    localparam int NV    = 7;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        busy;
    logic        txd;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .busy(busy), .txd(txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int s);
        if (s == 0) return 1'b0;
        if (s <= 8) return d[s-1];
`ifdef UART_TX_PARITY_EN
        if (s == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Bench receiver: mid-bit sampling from the first low sample of the start bit
    logic [7:0]  rx_q[$];
    int unsigned start_q[$];
    int          rx_errs = 0;
    bit          rx_ab;
    logic [7:0]  rx_d;
    int unsigned rx_st;

    task automatic rx_wait(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (reset) begin
                ab = 1'b1;
                break;
            end
        end
    endtask

    initial begin : rx
        forever begin
            @(negedge clk);
            if (!reset && txd == 1'b0) begin
                rx_st = cyc;
                rx_wait(C / 2, rx_ab);
                if (!rx_ab && txd !== 1'b0) rx_errs++;
                for (int k = 0; k < 8; k++) begin
                    if (!rx_ab) begin
                        rx_wait(C, rx_ab);
                        rx_d[k] = txd;
                    end
                end
`ifdef UART_TX_PARITY_EN
                if (!rx_ab) begin
                    rx_wait(C, rx_ab);
                    if (!rx_ab && txd !== ^rx_d) rx_errs++;
                end
`endif
                if (!rx_ab) rx_wait(C, rx_ab);
                if (!rx_ab) begin
                    if (txd !== 1'b1) rx_errs++;
                    rx_q.push_back(rx_d);
                    start_q.push_back(rx_st);
                end
            end
        end
    end

    task automatic wait_busy(input logic lvl, input int limit, input string name);
        int k = 0;
        while (busy !== lvl && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(busy), 32'(lvl));
    endtask

    task automatic wait_rx(input int n, input int limit, input string name);
        int k = 0;
        while (rx_q.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(name, rx_q.size(), n);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       we;
        logic [7:0] d;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       bsy;
        logic       tx;
    } vec_t;

    vec_t vecs[NV];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin : main
        int bad;
        int bcnt;
        int lows;
        logic exp;
        logic [7:0] expb[$];

        // reset held with wr_en pulsed, release, then one write and its pop
        vecs[0] = '{1'b1, 1'b1, 8'hAA, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 8'hAB, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 8'hAC, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 8'h34, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < NV; i++) begin
            reset   = vecs[i].rst;
            wr_en   = vecs[i].we;
            wr_data = vecs[i].d;
            @(negedge clk);
            check($sformatf("vec%0d_count", i), 32'(count), vecs[i].cnt);
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
            check($sformatf("vec%0d_full", i),  32'(full),  32'(vecs[i].ful));
            check($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].bsy));
            check($sformatf("vec%0d_txd", i),   32'(txd),   32'(vecs[i].tx));
        end
        wr_en = 1'b0;

        // single byte 0x34: every cycle of the frame checked, current negedge is frame cycle 0
        bad  = 0;
        bcnt = 0;
        for (int j = 0; j < FRAME + 5; j++) begin
            if (j > 0) @(negedge clk);
            if (busy === 1'b1) bcnt++;
            exp = (j < FRAME) ? frame_bit(8'h34, j / C) : 1'b1;
            if (txd !== exp) bad++;
        end
        check("single_wave_bad_cycles", bad, 0);
        check("single_busy_cycles", bcnt, FRAME);
        check("single_rx_size", rx_q.size(), 1);
        if (rx_q.size() > 0) check("single_rx_byte", 32'(rx_q[0]), 32'h34);

        // back-to-back 0x34, 0x35, 0x2F
        rx_q.delete();
        start_q.delete();
        write_byte(8'h34);
        write_byte(8'h35);
        write_byte(8'h2F);
        wait_rx(3, 3 * (FRAME + 1) + 2 * C, "b2b_rx_timeout");
        expb = '{8'h34, 8'h35, 8'h2F};
        for (int i = 0; i < 3 && i < rx_q.size(); i++)
            check($sformatf("b2b_byte%0d", i), 32'(rx_q[i]), 32'(expb[i]));
        for (int i = 1; i < 3 && i < start_q.size(); i++)
            check($sformatf("b2b_gap%0d", i), start_q[i] - start_q[i-1], FRAME + 1);
        wait_busy(1'b0, 2 * C, "b2b_idle_timeout");

        // overflow: 17 writes while the first frame is in its start bit
        rx_q.delete();
        start_q.delete();
        write_byte(8'hA5);
        wait_busy(1'b1, 10, "ovf_start_timeout");
        for (int i = 0; i < 17; i++) write_byte(8'(i));
        check("ovf_count", 32'(count), 16);
        check("ovf_full", 32'(full), 1);
        check("ovf_empty", 32'(empty), 0);
        wait_rx(17, 17 * (FRAME + 1) + 2 * C, "ovf_rx_timeout");
        expb.delete();
        expb.push_back(8'hA5);
        for (int i = 0; i < 16; i++) expb.push_back(8'(i));
        bad = 0;
        for (int i = 0; i < 17 && i < rx_q.size(); i++) if (rx_q[i] !== expb[i]) bad++;
        check("ovf_byte_mismatches", bad, 0);
        bad = 0;
        for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != FRAME + 1) bad++;
        check("ovf_gap_mismatches", bad, 0);
        wait_busy(1'b0, 2 * C, "ovf_idle_timeout");
        repeat (10) @(negedge clk);
        check("ovf_no_extra_frame", rx_q.size(), 17);
        check("ovf_drained_count", 32'(count), 0);

        // simultaneous push and pop with count = 5
        rx_q.delete();
        start_q.delete();
        write_byte(8'hC3);
        wait_busy(1'b1, 10, "pp_start_timeout");
        for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i));
        check("pp_count_before", 32'(count), 5);
        wait_busy(1'b0, FRAME + 10, "pp_idle_timeout");
        check("pp_idle_count", 32'(count), 5);
        write_byte(8'h55);
        check("pp_count_after", 32'(count), 5);
        check("pp_busy_after", 32'(busy), 1);
        wait_rx(7, 7 * (FRAME + 1) + 2 * C, "pp_rx_timeout");
        expb = '{8'hC3, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        bad = 0;
        for (int i = 0; i < 7 && i < rx_q.size(); i++) if (rx_q[i] !== expb[i]) bad++;
        check("pp_byte_mismatches", bad, 0);
        wait_busy(1'b0, 2 * C, "pp_drain_timeout");

        // reset in the middle of data bit 3 of 0x39 with two bytes still queued
        rx_q.delete();
        start_q.delete();
        write_byte(8'h39);
        wait_busy(1'b1, 10, "rst_start_timeout");
        write_byte(8'h11);
        write_byte(8'h22);
        repeat (4 * C + C / 2 - 2) @(negedge clk);
        check("rst_pre_count", 32'(count), 2);
        check("rst_pre_txd_bit3", 32'(txd), 1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_txd", 32'(txd), 1);
        check("rst_async_busy", 32'(busy), 0);
        check("rst_async_count", 32'(count), 0);
        check("rst_async_empty", 32'(empty), 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lows = 0;
        bcnt = 0;
        for (int j = 0; j < 2 * FRAME; j++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
            if (busy !== 1'b0) bcnt++;
        end
        check("rst_post_txd_low_cycles", lows, 0);
        check("rst_post_busy_cycles", bcnt, 0);
        check("rst_post_rx_frames", rx_q.size(), 0);

        check("rx_framing_errors", rx_errs, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
